// File: rtl/alu_pkg.sv
// Shared opcode and shift-direction definitions for the pipelined ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOTA = 3'b011,
      OP_NOTB = 3'b100,
      OP_ADD  = 3'b101,
      OP_ADC  = 3'b110,
      OP_SUB  = 3'b111
   } opCode_e;

   localparam logic SH_LEFT  = 1'b0;
   localparam logic SH_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// Zero-filling logical shifter applied to each operand ahead of stage 1.
module alu_shifter
   import alu_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] dataIn,
   input  logic [SHW-1:0]   shiftIn,
   input  logic             dirIn,
   output logic [WIDTH-1:0] dataOut
);

   always_comb begin
      if (dirIn == SH_RIGHT) dataOut = dataIn >> shiftIn;
      else                   dataOut = dataIn << shiftIn;
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready on both sides, a chaining carry
// register for ADC and a held positive-difference register.
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clockIn,
   input  logic             resetIn,
   input  logic             validIn,
   output logic             readyOut,
   input  logic [WIDTH-1:0] aIn,
   input  logic [WIDTH-1:0] bIn,
   input  logic [2:0]       opCode,
   input  logic [SHW-1:0]   shiftIn,
   input  logic             shiftDirIn,
   output logic             validOut,
   input  logic             readyIn,
   output logic [WIDTH-1:0] accOut,
   output logic             crOut,
   output logic             zeroFlag,
   output logic             negFlag,
   output logic             ovfFlag,
   output logic [WIDTH-1:0] diffOut
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      opCode_e          op;
   } stage1_t;

   logic [WIDTH-1:0] aShift, bShift;
   stage1_t          s1q;
   logic             v1, carryReg, advance2;
   logic [WIDTH:0]   arith;
   logic [WIDTH-1:0] res;
   logic             cr, ovf, isArith, isSub;

   alu_shifter #(.WIDTH(WIDTH)) shA (
      .dataIn(aIn), .shiftIn(shiftIn),
      .dirIn(shiftDirIn), .dataOut(aShift)
   );

   alu_shifter #(.WIDTH(WIDTH)) shB (
      .dataIn(bIn), .shiftIn(shiftIn),
      .dirIn(shiftDirIn), .dataOut(bShift)
   );

   assign advance2 = !validOut || readyIn;
   assign readyOut = !v1 || advance2;

   always_comb begin
      arith   = '0;
      res     = '0;
      cr      = 1'b0;
      ovf     = 1'b0;
      isArith = 1'b0;
      isSub   = 1'b0;
      unique case (s1q.op)
         OP_AND:  res = s1q.a & s1q.b;
         OP_OR:   res = s1q.a | s1q.b;
         OP_XOR:  res = s1q.a ^ s1q.b;
         OP_NOTA: res = ~s1q.a;
         OP_NOTB: res = ~s1q.b;
         OP_ADD: begin
            arith   = {1'b0, s1q.a} + {1'b0, s1q.b};
            isArith = 1'b1;
         end
         OP_ADC: begin
            arith   = {1'b0, s1q.a} + {1'b0, s1q.b}
                    + (WIDTH+1)'(carryReg);
            isArith = 1'b1;
         end
         OP_SUB: begin
            arith   = {1'b0, s1q.a} - {1'b0, s1q.b};
            isArith = 1'b1;
            isSub   = 1'b1;
         end
      endcase
      if (isArith) begin
         res = arith[WIDTH-1:0];
         cr  = arith[WIDTH];
         // signed overflow judged on operand and result sign bits
         if (isSub)
            ovf = (s1q.a[WIDTH-1] != s1q.b[WIDTH-1])
               && (res[WIDTH-1] != s1q.a[WIDTH-1]);
         else
            ovf = (s1q.a[WIDTH-1] == s1q.b[WIDTH-1])
               && (res[WIDTH-1] != s1q.a[WIDTH-1]);
      end
   end

   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         v1       <= 1'b0;
         s1q      <= '0;
         validOut <= 1'b0;
         accOut   <= '0;
         crOut    <= 1'b0;
         zeroFlag <= 1'b0;
         negFlag  <= 1'b0;
         ovfFlag  <= 1'b0;
         diffOut  <= '0;
         carryReg <= 1'b0;
      end else begin
         if (readyOut) begin
            v1 <= validIn;
            if (validIn)
               s1q <= '{a: aShift, b: bShift, op: opCode_e'(opCode)};
         end
         if (advance2) begin
            validOut <= v1;
            if (v1) begin
               accOut   <= res;
               crOut    <= cr;
               zeroFlag <= (res == '0);
               negFlag  <= res[WIDTH-1];
               ovfFlag  <= ovf;
               if (isArith) carryReg <= cr;
               if (isSub && (s1q.a > s1q.b)) diffOut <= res;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector table plus backpressure and mid-stream reset sequences.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clockIn = 1'b0;
   logic        resetIn, validIn, readyOut, readyIn;
   logic [15:0] aIn, bIn, accOut, diffOut;
   logic [2:0]  opCode;
   logic [3:0]  shiftIn;
   logic        shiftDirIn, validOut;
   logic        crOut, zeroFlag, negFlag, ovfFlag;

   int checks = 0;
   int failures = 0;

   alu_pipe #(.WIDTH(16)) dut (
      .clockIn(clockIn), .resetIn(resetIn),
      .validIn(validIn), .readyOut(readyOut),
      .aIn(aIn), .bIn(bIn), .opCode(opCode),
      .shiftIn(shiftIn), .shiftDirIn(shiftDirIn),
      .validOut(validOut), .readyIn(readyIn),
      .accOut(accOut), .crOut(crOut),
      .zeroFlag(zeroFlag), .negFlag(negFlag),
      .ovfFlag(ovfFlag), .diffOut(diffOut)
   );

   always #5 clockIn = ~clockIn;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sh;
      logic        dir;
      logic [15:0] acc;
      logic        cr;
      logic        z;
      logic        n;
      logic        v;
      logic [15:0] diff;
   } vec_t;

   vec_t vecs[19];

   task automatic step();
      @(posedge clockIn);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh,
                        input logic dir);
      validIn    = 1'b1;
      opCode     = op;
      aIn        = a;
      bIn        = b;
      shiftIn    = sh;
      shiftDirIn = dir;
   endtask

   initial begin
      logic [15:0] gotQ[$];
      int          sent, holdErr, dropSent;
      logic [15:0] prevAcc, expV;
      logic        prevStall;

      vecs[0]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 4'd0,  1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[2]  = '{OP_ADC,  16'h0000, 16'h0000, 4'd0,  1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[3]  = '{OP_ADD,  16'h2000, 16'h2000, 4'd1,  1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[4]  = '{OP_SUB,  16'h0010, 16'h0003, 4'd0,  1'b0, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000D};
      vecs[5]  = '{OP_SUB,  16'h0002, 16'h0005, 4'd0,  1'b0, 16'hFFFD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000D};
      vecs[6]  = '{OP_OR,   16'h1200, 16'h0034, 4'd0,  1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000D};
      vecs[7]  = '{OP_XOR,  16'hFFFF, 16'h00FF, 4'd0,  1'b0, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000D};
      vecs[8]  = '{OP_NOTA, 16'h0000, 16'h1234, 4'd0,  1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000D};
      vecs[9]  = '{OP_NOTB, 16'h1234, 16'hFFFF, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000D};
      vecs[10] = '{OP_AND,  16'hF0F0, 16'h0FF0, 4'd4,  1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000D};
      vecs[11] = '{OP_SUB,  16'h8000, 16'h0001, 4'd0,  1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF};
      vecs[12] = '{OP_ADD,  16'h7FFF, 16'h0001, 4'd0,  1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF};
      vecs[13] = '{OP_ADD,  16'hFFFF, 16'hFFFF, 4'd0,  1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7FFF};
      vecs[14] = '{OP_ADC,  16'h0001, 16'h0001, 4'd0,  1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF};
      vecs[15] = '{OP_SUB,  16'h0005, 16'h0005, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF};
      vecs[16] = '{OP_ADD,  16'h0001, 16'h0003, 4'd15, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7FFF};
      vecs[17] = '{OP_AND,  16'hFFFF, 16'hFFFF, 4'd0,  1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF};
      vecs[18] = '{OP_ADC,  16'h0000, 16'h0000, 4'd0,  1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF};

      resetIn = 1'b1;
      readyIn = 1'b1;
      drive(OP_AND, 16'h0, 16'h0, 4'd0, 1'b0);
      validIn = 1'b0;
      step();
      step();
      resetIn = 1'b0;
      check("rst validOut", 32'(validOut), 32'(1'b0));
      check("rst accOut",   32'(accOut),   32'h0);
      check("rst diffOut",  32'(diffOut),  32'h0);
      check("rst flags", 32'({crOut, zeroFlag, negFlag, ovfFlag}), 32'h0);
      check("rst readyOut", 32'(readyOut), 32'(1'b1));

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].dir);
         step();
         validIn = 1'b0;
         step();
         check($sformatf("vec%0d valid", i), 32'(validOut), 32'(1'b1));
         check($sformatf("vec%0d acc", i), 32'(accOut), 32'(vecs[i].acc));
         check($sformatf("vec%0d cr", i), 32'(crOut), 32'(vecs[i].cr));
         check($sformatf("vec%0d zero", i), 32'(zeroFlag), 32'(vecs[i].z));
         check($sformatf("vec%0d neg", i), 32'(negFlag), 32'(vecs[i].n));
         check($sformatf("vec%0d ovf", i), 32'(ovfFlag), 32'(vecs[i].v));
         check($sformatf("vec%0d diff", i), 32'(diffOut), 32'(vecs[i].diff));
      end
      step();

      // backpressure: readyIn low for four cycles while five beats stream in
      sent = 0;
      holdErr = 0;
      dropSent = -1;
      prevStall = 1'b0;
      prevAcc = '0;
      for (int cyc = 0; cyc < 40 && gotQ.size() < 5; cyc++) begin
         readyIn = !(cyc >= 1 && cyc <= 4);
         if (sent < 5)
            drive(OP_XOR, 16'(16'h1111 * sent), 16'h00FF, 4'd0, 1'b0);
         else
            validIn = 1'b0;
         #1;
         if (prevStall && (!validOut || accOut != prevAcc)) holdErr++;
         if (!readyOut && dropSent < 0) dropSent = sent;
         prevStall = validOut && !readyIn;
         prevAcc = accOut;
         if (validOut && readyIn) gotQ.push_back(accOut);
         if (validIn && readyOut) sent++;
         step();
      end
      validIn = 1'b0;
      readyIn = 1'b1;
      check("bp beat count", 32'(gotQ.size()), 32'd5);
      for (int k = 0; k < gotQ.size() && k < 5; k++) begin
         expV = 16'(16'h1111 * k) ^ 16'h00FF;
         check($sformatf("bp beat%0d", k), 32'(gotQ[k]), 32'(expV));
      end
      check("bp hold", 32'(holdErr), 32'd0);
      check("bp readyOut drop", 32'(dropSent), 32'd2);
      step();
      step();

      // reset while both stages hold a carry-producing ADD
      readyIn = 1'b0;
      drive(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 1'b0);
      step();
      step();
      validIn = 1'b0;
      check("full validOut", 32'(validOut), 32'(1'b1));
      check("full readyOut", 32'(readyOut), 32'(1'b0));
      resetIn = 1'b1;
      step();
      resetIn = 1'b0;
      check("mid rst validOut", 32'(validOut), 32'(1'b0));
      check("mid rst accOut",   32'(accOut),   32'h0);
      check("mid rst diffOut",  32'(diffOut),  32'h0);
      check("mid rst flags", 32'({crOut, zeroFlag, negFlag, ovfFlag}), 32'h0);
      check("mid rst readyOut", 32'(readyOut), 32'(1'b1));
      step();
      check("mid rst flushed", 32'(validOut), 32'(1'b0));
      readyIn = 1'b1;
      drive(OP_ADC, 16'h0000, 16'h0000, 4'd0, 1'b0);
      step();
      validIn = 1'b0;
      step();
      check("post rst adc valid", 32'(validOut), 32'(1'b1));
      check("post rst adc acc",   32'(accOut),   32'h0);
      check("post rst adc zero",  32'(zeroFlag), 32'(1'b1));
      check("post rst adc cr",    32'(crOut),    32'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
